// File: rtl/timing2.sv
// Bus-cycle timing generator: splits the 16 MHz clock into a 16-slot frame and
// derives the 8 MHz clock, slot strobes and CPU half-frame controls from it.
module timing2 #(
    parameter int SPI_SLOT       = 6,
    parameter int VIDEO_SLOT     = 2,
    parameter int CPU_SLOT_START = 8
) (
    input  logic       clk_16_i,
    input  logic       reset_i,
    output logic       clk_8_o,
    output logic       spi_enable_o,
    output logic       video_enable_o,
    output logic       cpu_be_o,
    output logic       cpu_enable_o,
    output logic       clk_1_o,
    output logic [3:0] count_o
);

    localparam int N_STROBES = 3;
    localparam logic [3:0] CPU_START_CNT = 4'(CPU_SLOT_START);
    // Strobe index 0 = SPI, 1 = video, 2 = CPU phi2 end (last slot of frame).
    localparam logic [N_STROBES-1:0][3:0] STROBE_SLOT =
        {4'd15, 4'(VIDEO_SLOT), 4'(SPI_SLOT)};

    generate
        if (SPI_SLOT == VIDEO_SLOT || SPI_SLOT < 0 || VIDEO_SLOT < 0 ||
            SPI_SLOT >= CPU_SLOT_START || VIDEO_SLOT >= CPU_SLOT_START ||
            CPU_SLOT_START < 1 || CPU_SLOT_START > 15) begin : g_bad_params
            $fatal(1, "timing2: illegal slot parameters");
        end
    endgenerate

    logic [3:0]           count_reg;
    logic [3:0]           count_next;
    logic                 clk_8_reg;
    logic                 cpu_be_reg;
    logic [N_STROBES-1:0] strobe_bits;

    always_comb begin
        count_next = count_reg + 4'd1;
    end

    // Outputs are registered from count_next so they line up with count_o.
    always_ff @(posedge clk_16_i or posedge reset_i) begin
        if (reset_i) begin
            count_reg  <= 4'd0;
            clk_8_reg  <= 1'b0;
            cpu_be_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            clk_8_reg  <= ~clk_8_reg;
            cpu_be_reg <= (count_next >= CPU_START_CNT);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_STROBES; gi++) begin : g_strobe
            logic hit_reg;
            always_ff @(posedge clk_16_i or posedge reset_i) begin
                if (reset_i) begin
                    hit_reg <= 1'b0;
                end else begin
                    hit_reg <= (count_next == STROBE_SLOT[gi]);
                end
            end
            assign strobe_bits[gi] = hit_reg;
        end
    endgenerate

    assign count_o        = count_reg;
    assign clk_8_o        = clk_8_reg;
    assign cpu_be_o       = cpu_be_reg;
    assign clk_1_o        = cpu_be_reg;
    assign spi_enable_o   = strobe_bits[0];
    assign video_enable_o = strobe_bits[1];
    assign cpu_enable_o   = strobe_bits[2];

endmodule

// File: tb/tb_timing2.sv
// Directed bench for timing2: reset hold, frame sequence, 4-frame pulse counts,
// slot alignment and asynchronous mid-frame reset.
`timescale 1ns/1ps
module tb_timing2;

    logic       clk_16;
    logic       reset;
    logic       clk_8;
    logic       spi_en;
    logic       video_en;
    logic       cpu_be;
    logic       cpu_en;
    logic       clk_1;
    logic [3:0] count;

    int total = 0;
    int bad   = 0;

    timing2 dut (
        .clk_16_i      (clk_16),
        .reset_i       (reset),
        .clk_8_o       (clk_8),
        .spi_enable_o  (spi_en),
        .video_enable_o(video_en),
        .cpu_be_o      (cpu_be),
        .cpu_enable_o  (cpu_en),
        .clk_1_o       (clk_1),
        .count_o       (count)
    );

    initial clk_16 = 1'b0;
    always #31.25 clk_16 = ~clk_16;

    // Packed as {clk_8, spi, video, cpu_be, cpu_en, clk_1}.
    logic [5:0] outs;
    assign outs = {clk_8, spi_en, video_en, cpu_be, cpu_en, clk_1};

    logic [5:0] exp_tab [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0h at %0t", tag, got, $time);
        end
    endtask

    initial begin
        int exp_cnt;
        int n_spi, n_video, n_cpu_en, n_be, n_overlap, n_bad_gap;
        int last_spi, last_video, last_cpu_en;
        int frame1_spi;
        bit found;

        exp_tab[0]  = 6'b000000;
        exp_tab[1]  = 6'b100000;
        exp_tab[2]  = 6'b001000;
        exp_tab[3]  = 6'b100000;
        exp_tab[4]  = 6'b000000;
        exp_tab[5]  = 6'b100000;
        exp_tab[6]  = 6'b010000;
        exp_tab[7]  = 6'b100000;
        exp_tab[8]  = 6'b000101;
        exp_tab[9]  = 6'b100101;
        exp_tab[10] = 6'b000101;
        exp_tab[11] = 6'b100101;
        exp_tab[12] = 6'b000101;
        exp_tab[13] = 6'b100101;
        exp_tab[14] = 6'b000101;
        exp_tab[15] = 6'b100111;

        // Reset held with the clock running.
        reset = 1'b1;
        #1;
        chk("rst_outs", 32'(outs), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        while ($realtime < 100.0) begin
            @(negedge clk_16);
            chk("rst_outs", 32'(outs), 32'h0);
            chk("rst_count", 32'(count), 32'h0);
        end
        reset = 1'b0;

        // Four frames: per-cycle table check plus pulse statistics.
        exp_cnt = 0;
        n_spi = 0; n_video = 0; n_cpu_en = 0; n_be = 0; n_overlap = 0; n_bad_gap = 0;
        last_spi = -1; last_video = -1; last_cpu_en = -1; frame1_spi = 0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk_16);
            exp_cnt = (exp_cnt + 1) % 16;
            chk("count", 32'(count), 32'(exp_cnt));
            chk("outs", 32'(outs), 32'(exp_tab[exp_cnt]));
            if (spi_en) begin
                n_spi++;
                if (cyc < 16) frame1_spi++;
                if (last_spi >= 0 && cyc - last_spi != 16) n_bad_gap++;
                last_spi = cyc;
            end
            if (video_en) begin
                n_video++;
                if (last_video >= 0 && cyc - last_video != 16) n_bad_gap++;
                last_video = cyc;
            end
            if (cpu_en) begin
                n_cpu_en++;
                if (last_cpu_en >= 0 && cyc - last_cpu_en != 16) n_bad_gap++;
                last_cpu_en = cyc;
            end
            if (cpu_be) n_be++;
            if (spi_en && cpu_be) n_overlap++;
        end
        chk("frame1_spi", 32'(frame1_spi), 32'd1);
        chk("n_spi", 32'(n_spi), 32'd4);
        chk("n_video", 32'(n_video), 32'd4);
        chk("n_cpu_en", 32'(n_cpu_en), 32'd4);
        chk("n_be_cycles", 32'(n_be), 32'd32);
        chk("pulse_gap", 32'(n_bad_gap), 32'd0);
        chk("spi_be_overlap", 32'(n_overlap), 32'd0);

        // Asynchronous reset between edges at count 11 (cpu_be and clk_8 both high).
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk_16);
            if (count == 4'd11) found = 1'b1;
        end
        chk("reach_11", 32'(found), 32'd1);
        chk("pre_rst_outs", 32'(outs), 32'(exp_tab[11]));
        #10;
        reset = 1'b1;
        #1;
        chk("async_cpu_be", 32'(cpu_be), 32'd0);
        chk("async_clk_8", 32'(clk_8), 32'd0);
        chk("async_outs", 32'(outs), 32'h0);
        chk("async_count", 32'(count), 32'h0);
        @(negedge clk_16);
        chk("rst_hold_outs", 32'(outs), 32'h0);
        reset = 1'b0;

        exp_cnt = 0;
        for (int cyc = 0; cyc < 18; cyc++) begin
            @(negedge clk_16);
            exp_cnt = (exp_cnt + 1) % 16;
            chk("restart_count", 32'(count), 32'(exp_cnt));
            chk("restart_outs", 32'(outs), 32'(exp_tab[exp_cnt]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        bad++;
        $display("FAIL timeout: simulation exceeded 20000 ns");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
